// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared definitions for the stopwatch lap controller: FSM state encoding.
package stopwatch_lap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_LAP  = 3'd2,
    ST_STOP = 3'd3,
    ST_SAVE = 3'd4,
    ST_SHOW = 3'd5
  } state_t;

endpackage

// File: rtl/stopwatch_lap_ctrl_display_mux.sv
// Selects live or recalled time for the display.
module display_mux #(
  parameter int TIME_W = 32
) (
  input  logic              sel,
  input  logic [TIME_W-1:0] live,
  input  logic [TIME_W-1:0] recall,
  output logic [TIME_W-1:0] out_time
);

  assign out_time = sel ? recall : live;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: run/stop FSM, circular lap memory pointers and
// newest-to-oldest browsing of stored laps.
module stopwatch_lap_ctrl
  import stopwatch_lap_ctrl_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int ADDR_W  = $clog2(N_SLOTS),
  parameter int TIME_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              store,
  input  logic              load,
  input  logic              clear,
  input  logic [TIME_W-1:0] live_time,
  input  logic [TIME_W-1:0] recall_time,
  output logic              count_en,
  output logic              clear_time,
  output logic              write,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              select,
  output logic [TIME_W-1:0] disp_time,
  output logic [ADDR_W:0]   lap_count,
  output logic              full
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0]   N_W  = AW1'(N_SLOTS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SLOTS - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W:0]   lap_cnt;
  logic              store_q, load_q, clear_q;
  logic              clear_pulse;

  logic              store_r, load_r, clear_r;
  logic [ADDR_W-1:0] wr_ptr_nx;
  logic [ADDR_W:0]   lap_nx;
  logic [ADDR_W-1:0] k_step;
  logic [ADDR_W-1:0] k_eff;
  logic [ADDR_W:0]   rd_sum;
  logic [ADDR_W:0]   rd_mod;

  assign store_r = store & ~store_q;
  assign load_r  = load  & ~load_q;
  assign clear_r = clear & ~clear_q;

  assign wr_ptr_nx = (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
  assign lap_nx    = (lap_cnt == N_W) ? lap_cnt : lap_cnt + AW1'(1);
  assign k_step    = (({1'b0, k} + AW1'(1)) == lap_cnt) ? '0 : k + ADDR_W'(1);

  // (wr_ptr - 1 - k) mod N: the sum stays within 0..2N-2, so one
  // conditional subtract folds it back for any N_SLOTS.
  assign k_eff = (state == ST_SHOW) ? k : '0;
  always_comb begin
    rd_sum = {1'b0, wr_ptr} + N_W - AW1'(1) - {1'b0, k_eff};
    rd_mod = rd_sum;
    if (rd_sum >= N_W) begin
      rd_mod = rd_sum - N_W;
    end
  end
  assign rd_addr = (lap_cnt == '0) ? '0 : rd_mod[ADDR_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      k           <= '0;
      lap_cnt     <= '0;
      store_q     <= 1'b0;
      load_q      <= 1'b0;
      clear_q     <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      store_q     <= store;
      load_q      <= load;
      clear_q     <= clear;
      clear_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!en)          state <= ST_STOP;
          else if (store_r) state <= ST_LAP;
        end
        ST_LAP: begin
          state   <= en ? ST_RUN : ST_STOP;
          wr_ptr  <= wr_ptr_nx;
          lap_cnt <= lap_nx;
        end
        ST_STOP: begin
          if (en) begin
            state <= ST_RUN;
          end else if (clear_r) begin
            state       <= ST_IDLE;
            clear_pulse <= 1'b1;
            lap_cnt     <= '0;
            wr_ptr      <= '0;
            k           <= '0;
          end else if (store_r && !load_r) begin
            state <= ST_SAVE;
          end else if (load_r && !store_r && (lap_cnt != '0)) begin
            state <= ST_SHOW;
            k     <= '0;
          end
        end
        ST_SAVE: begin
          state   <= ST_STOP;
          wr_ptr  <= wr_ptr_nx;
          lap_cnt <= lap_nx;
        end
        ST_SHOW: begin
          if (en) begin
            state <= ST_RUN;
          end else if (clear_r) begin
            state       <= ST_IDLE;
            clear_pulse <= 1'b1;
            lap_cnt     <= '0;
            wr_ptr      <= '0;
            k           <= '0;
          end else if (load_r) begin
            k <= k_step;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode straight from the state register, so an async reset
  // kills the write strobe immediately.
  assign count_en   = (state == ST_RUN) || (state == ST_LAP);
  assign write      = (state == ST_LAP) || (state == ST_SAVE);
  assign select     = (state == ST_SHOW);
  assign wr_addr    = wr_ptr;
  assign clear_time = clear_pulse;
  assign lap_count  = lap_cnt;
  assign full       = (lap_cnt == N_W);

  display_mux #(.TIME_W(TIME_W)) u_display_mux (
    .sel      (select),
    .live     (live_time),
    .recall   (recall_time),
    .out_time (disp_time)
  );

endmodule
